eth_miim_sequencer: RTL and testbench

- Sequences MII management (MDIO) frames for the Ethernet MAC.
- Generates Mdc and its one-cycle strobes (MdcEn, MdcEn_n).
- Arbitrates write, read and scan-status requests, and drives InProgress/WriteOp/BitCounter to the shift register and output-control logic.
- Sits between the host register block and the MDIO serialiser.

---
 rtl/eth_miim_pkg.sv | 24 ++
 rtl/eth_miim_clkgen.sv | 49 ++++
 rtl/eth_miim_sequencer.sv | 154 +++++++++++++++
 tb/tb_eth_miim_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_miim_pkg.sv
// Shared types and constants for the MII management frame sequencer.
// Op and state enumerations plus frame-geometry constants.
package eth_miim_pkg;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_WRITE,
    OP_READ,
    OP_SCAN
  } opT;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    DONE
  } stateT;

  localparam int unsigned PREAMBLE_BITS = 32;
  // With the preamble suppressed the frame jumps from bit 0 straight past it.
  localparam int unsigned NOPRE_SKIP    = PREAMBLE_BITS + 1;
  localparam int unsigned FRAME_LAST    = 63;

endpackage

// File: rtl/eth_miim_clkgen.sv
// Management clock generator.
// Divides Clk down to Mdc and produces one-Clk strobes announcing each
// Mdc edge.
//   Clk      in  host clock
//   Reset    in  asynchronous active-high reset
//   Divider  in  [7:0] divide ratio (values below 2 act as 2, odd rounds down)
//   Mdc      out management clock
//   MdcEn    out high the Clk before Mdc rises
//   MdcEn_n  out high the Clk before Mdc falls
module eth_miim_clkgen
  import eth_miim_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] Divider,
  output logic       Mdc,
  output logic       MdcEn,
  output logic       MdcEn_n
);

  logic [7:0] count;
  logic [7:0] countNext;
  logic [7:0] loadVal;
  logic       mdcNext;

  // The strobes are registered from next-state values, so a strobe is high
  // exactly while count==0 and marks the Clk whose closing edge toggles Mdc.
  // Right after reset count is 0 with no strobe: that edge only reloads.
  always_comb begin
    loadVal   = (Divider < 8'd2) ? 8'd0 : (Divider >> 1) - 8'd1;
    countNext = (count == '0) ? loadVal : count - 8'd1;
    mdcNext   = (MdcEn || MdcEn_n) ? ~Mdc : Mdc;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count   <= '0;
      Mdc     <= 1'b0;
      MdcEn   <= 1'b0;
      MdcEn_n <= 1'b0;
    end else begin
      count   <= countNext;
      Mdc     <= mdcNext;
      MdcEn   <= (countNext == '0) && !mdcNext;
      MdcEn_n <= (countNext == '0) && mdcNext;
    end
  end

endmodule

// File: rtl/eth_miim_sequencer.sv
// MII management frame sequencer.
// Captures write/read requests (and continuous scan when built with
// ETH_MIIM_SCAN_EN), arbitrates write > read > scan and steps BitCounter
// through a frame on each Mdc falling strobe.
//   Clk, Reset         host clock, asynchronous active-high reset
//   Divider, NoPre     Mdc divide ratio, skip preamble
//   WCtrlData, RStat   one-Clk write / read request pulses
//   ScanStat           continuous-read level (ignored without ETH_MIIM_SCAN_EN)
//   Mdc, MdcEn, MdcEn_n management clock and edge strobes
//   InProgress, WriteOp, BitCounter  active-frame status
//   Busy               request pending or frame active
//   UpdateReadData     one-Clk pulse at the end of a read/scan frame
//   Nvalid             scan data not yet valid (0 without ETH_MIIM_SCAN_EN)
module eth_miim_sequencer
  import eth_miim_pkg::*;
#(
  parameter int          Tp         = 1,
  parameter int unsigned FRAME_LAST = eth_miim_pkg::FRAME_LAST
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] Divider,
  input  logic       NoPre,
  input  logic       WCtrlData,
  input  logic       RStat,
  input  logic       ScanStat,
  output logic       Mdc,
  output logic       MdcEn,
  output logic       MdcEn_n,
  output logic       InProgress,
  output logic       WriteOp,
  output logic [6:0] BitCounter,
  output logic       Busy,
  output logic       UpdateReadData,
  output logic       Nvalid
);

  localparam logic [6:0] LAST_BIT = 7'(FRAME_LAST);
  localparam logic [6:0] SKIP_BIT = 7'(NOPRE_SKIP);
  localparam int         unusedTp = Tp;

  stateT state;
  opT    op;
  logic  writePend;
  logic  readPend;
  logic  scanReq;
  logic  frameEnd;

  eth_miim_clkgen uClkgen (
    .Clk     (Clk),
    .Reset   (Reset),
    .Divider (Divider),
    .Mdc     (Mdc),
    .MdcEn   (MdcEn),
    .MdcEn_n (MdcEn_n)
  );

  assign frameEnd = (state == RUN) && MdcEn_n && (BitCounter == LAST_BIT);
  assign Busy     = writePend || readPend || (state != IDLE);

`ifdef ETH_MIIM_SCAN_EN
  logic scanSeen;
  logic nvalidQ;
  logic scanAccept;

  assign scanReq    = ScanStat;
  assign scanAccept = (state == IDLE) && MdcEn_n && !writePend && !readPend && ScanStat;
  assign Nvalid     = nvalidQ;

  // scanSeen marks that the current ScanStat high period already started a
  // scan, so only the first scan after ScanStat rises raises Nvalid.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      scanSeen <= 1'b0;
      nvalidQ  <= 1'b0;
    end else if (!ScanStat) begin
      scanSeen <= 1'b0;
      nvalidQ  <= 1'b0;
    end else if (scanAccept && !scanSeen) begin
      scanSeen <= 1'b1;
      nvalidQ  <= 1'b1;
    end else if (frameEnd && (op == OP_SCAN)) begin
      nvalidQ  <= 1'b0;
    end
  end
`else
  logic unusedScanStat;
  assign unusedScanStat = ScanStat;
  assign scanReq        = 1'b0;
  assign Nvalid         = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state          <= IDLE;
      op             <= OP_NONE;
      writePend      <= 1'b0;
      readPend       <= 1'b0;
      InProgress     <= 1'b0;
      WriteOp        <= 1'b0;
      BitCounter     <= '0;
      UpdateReadData <= 1'b0;
    end else begin
      UpdateReadData <= 1'b0;
      // A pulse while its flag is already set changes nothing (dropped).
      if (WCtrlData) writePend <= 1'b1;
      if (RStat)     readPend  <= 1'b1;

      case (state)
        IDLE: begin
          if (MdcEn_n && (writePend || readPend || scanReq)) begin
            state      <= START;
            InProgress <= 1'b1;
            BitCounter <= '0;
            if (writePend) begin
              op        <= OP_WRITE;
              WriteOp   <= 1'b1;
              writePend <= 1'b0;
            end else if (readPend) begin
              op        <= OP_READ;
              readPend  <= 1'b0;
            end else begin
              op        <= OP_SCAN;
            end
          end
        end
        START: begin
          // Leaving START is the first counted step, hence the NoPre skip here.
          if (MdcEn_n) begin
            state      <= RUN;
            BitCounter <= NoPre ? SKIP_BIT : 7'd1;
          end
        end
        RUN: begin
          if (frameEnd) begin
            state          <= DONE;
            InProgress     <= 1'b0;
            WriteOp        <= 1'b0;
            BitCounter     <= '0;
            UpdateReadData <= (op == OP_READ) || (op == OP_SCAN);
          end else if (MdcEn_n) begin
            BitCounter <= BitCounter + 7'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          op    <= OP_NONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_miim_sequencer.sv
module tb_eth_miim_sequencer;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] Divider = 8'd8;
  logic       NoPre = 1'b0;
  logic       WCtrlData = 1'b0;
  logic       RStat = 1'b0;
  logic       ScanStat = 1'b0;
  logic       Mdc, MdcEn, MdcEn_n, InProgress, WriteOp, Busy, UpdateReadData, Nvalid;
  logic [6:0] BitCounter;

  int checks = 0;
  int failures = 0;

`ifdef ETH_MIIM_SCAN_EN
  localparam bit SCAN_ON = 1'b1;
`else
  localparam bit SCAN_ON = 1'b0;
`endif

  always #5 Clk = ~Clk;

  eth_miim_sequencer #(.Tp(1), .FRAME_LAST(63)) dut (
    .Clk(Clk), .Reset(Reset), .Divider(Divider), .NoPre(NoPre),
    .WCtrlData(WCtrlData), .RStat(RStat), .ScanStat(ScanStat),
    .Mdc(Mdc), .MdcEn(MdcEn), .MdcEn_n(MdcEn_n),
    .InProgress(InProgress), .WriteOp(WriteOp), .BitCounter(BitCounter),
    .Busy(Busy), .UpdateReadData(UpdateReadData), .Nvalid(Nvalid)
  );

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  // A frame is a list of bit indices (0..63, or 0,33..63 without preamble)
  // walked one entry per Mdc falling strobe; a one-Clk done gap follows.
  bit mActive, mDone, mUpd, pendW, pendR, mNoPre, mNv, mSeen;
  bit prevMdc, prevEn, prevEnN;
  int mPos, mLast, mOp; // mOp: 0 write, 1 read, 2 scan

  function automatic int expIdx();
    if (!mActive || mPos == 0) return 0;
    return mNoPre ? mPos + 32 : mPos;
  endfunction

  always @(negedge Clk) begin
    bit started, ended;
    if (Reset) begin
      mActive = 0; mDone = 0; mUpd = 0; pendW = 0; pendR = 0; mNv = 0; mSeen = 0;
      mPos = 0; mLast = 0; mOp = 0; mNoPre = 0;
      prevMdc = 0; prevEn = 0; prevEnN = 0;
    end else begin
      chk("InProgress", InProgress, mActive);
      chk("WriteOp", WriteOp, mActive && mOp == 0);
      chk("BitCounter", BitCounter, expIdx());
      chk("Busy", Busy, pendW || pendR || mActive || mDone);
      chk("UpdateReadData", UpdateReadData, mUpd);
      chk("Nvalid", Nvalid, mNv);
      // Mdc may only move on the edge right after its matching strobe.
      chk("MdcStep", {prevMdc, Mdc}, prevEn ? 1 : (prevEnN ? 2 : (prevMdc ? 3 : 0)));
      chk("StrobeExcl", MdcEn && MdcEn_n, 0);

      started = 0; ended = 0; mUpd = 0;
      if (mDone) mDone = 0;
      else if (mActive) begin
        if (MdcEn_n) begin
          if (mPos == mLast) begin
            mActive = 0; mDone = 1; mUpd = (mOp != 0); ended = 1;
          end else mPos++;
        end
      end else if (MdcEn_n && (pendW || pendR || (SCAN_ON && ScanStat))) begin
        mActive = 1; mPos = 0; mNoPre = NoPre; mLast = NoPre ? 31 : 63; started = 1;
        if (pendW) begin mOp = 0; pendW = 0; end
        else if (pendR) begin mOp = 1; pendR = 0; end
        else mOp = 2;
      end
      if (WCtrlData) pendW = 1;
      if (RStat) pendR = 1;
      if (!ScanStat) begin mNv = 0; mSeen = 0; end
      else if (started && mOp == 2 && !mSeen) begin mNv = 1; mSeen = 1; end
      else if (ended && mOp == 2) mNv = 0;

      prevMdc = Mdc; prevEn = MdcEn; prevEnN = MdcEn_n;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse(input bit w, input bit r);
    @(posedge Clk); #2; WCtrlData = w; RStat = r;
    @(posedge Clk); #2; WCtrlData = 0; RStat = 0;
  endtask

  task automatic measure(output int per, output int nEnN);
    bit pm;
    int guard;
    per = 0; nEnN = 0; guard = 0;
    do begin pm = Mdc; @(negedge Clk); guard++; end while (!(!pm && Mdc) && guard < 100);
    do begin pm = Mdc; @(negedge Clk); per++; if (MdcEn_n) nEnN++; end
      while (!(!pm && Mdc) && per < 100);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int per, nEn, cnt, sum, upd, bad, mx, frames, starts, lowBusy, updAt, hits, k;
    int seq[3];
    int wo[2];
    bit seen, prevIP, found;

    // ---- reset values ----
    #1 Reset = 1;
    #10;
    chk("rst_Mdc", Mdc, 0);
    chk("rst_MdcEn", MdcEn, 0);
    chk("rst_MdcEn_n", MdcEn_n, 0);
    chk("rst_InProgress", InProgress, 0);
    chk("rst_BitCounter", BitCounter, 0);
    chk("rst_Busy", Busy, 0);
    chk("rst_Update", UpdateReadData, 0);
    chk("rst_Nvalid", Nvalid, 0);
    @(posedge Clk); #2 Reset = 0;

    // ---- 1: clock generator ----
    measure(per, nEn);
    chk("t1_period_div8", per, 8);
    chk("t1_strobes_div8", nEn, 1);
    @(posedge Clk); #2 Divider = 8'd1;
    measure(per, nEn);
    measure(per, nEn);
    chk("t1_period_div1", per, 2);
    chk("t1_strobes_div1", nEn, 1);

    // ---- 2: single write frame ----
    @(posedge Clk); #2 Divider = 8'd4;
    measure(per, nEn);
    chk("t2_period_div4", per, 4);
    pulse(1, 0);
    cnt = 0; sum = 0; upd = 0; bad = 0; mx = 0; seen = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge Clk);
      if (InProgress) begin
        seen = 1;
        if (!WriteOp) bad++;
        if (BitCounter > mx) mx = BitCounter;
        if (MdcEn_n) begin cnt++; sum += BitCounter; end
      end
      if (UpdateReadData) upd++;
      if (seen && !Busy) break;
    end
    chk("t2_strobes", cnt, 64);
    chk("t2_bitsum", sum, 2016);
    chk("t2_maxbit", mx, 63);
    chk("t2_writeop_low", bad, 0);
    chk("t2_update", upd, 0);
    chk("t2_busy_end", Busy, 0);

    // ---- 3: write and read in the same Clk ----
    pulse(1, 1);
    frames = 0; starts = 0; lowBusy = 0; upd = 0; updAt = -1; prevIP = 0;
    wo[0] = -1; wo[1] = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clk);
      if (InProgress && !prevIP) begin
        if (starts < 2) wo[starts] = WriteOp;
        starts++;
      end
      if (!InProgress && prevIP) frames++;
      prevIP = InProgress;
      if (UpdateReadData) begin upd++; updAt = frames; end
      if (frames < 2 && !Busy) lowBusy++;
      if (frames == 2 && !Busy) break;
    end
    chk("t3_frames", starts, 2);
    chk("t3_first_write", wo[0], 1);
    chk("t3_second_read", wo[1], 0);
    chk("t3_updates", upd, 1);
    chk("t3_update_after", updAt, 2);
    chk("t3_busy_gaps", lowBusy, 0);

    // ---- 4: read without preamble ----
    @(posedge Clk); #2 NoPre = 1;
    pulse(0, 1);
    cnt = 0; sum = 0; upd = 0; seen = 0; k = 0;
    seq[0] = -1; seq[1] = -1; seq[2] = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge Clk);
      if (InProgress) begin
        seen = 1;
        if (MdcEn_n) begin
          if (k < 3) seq[k] = BitCounter;
          k++; cnt++; sum += BitCounter;
        end
      end
      if (UpdateReadData) upd++;
      if (seen && !Busy) break;
    end
    chk("t4_strobes", cnt, 32);
    chk("t4_seq0", seq[0], 0);
    chk("t4_seq1", seq[1], 33);
    chk("t4_seq2", seq[2], 34);
    chk("t4_bitsum", sum, 1488);
    chk("t4_updates", upd, 1);
    @(posedge Clk); #2 NoPre = 0;

    // ---- 5: reset mid-frame ----
    @(posedge Clk); #2 Divider = 8'd2;
    pulse(1, 0);
    found = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge Clk);
      if (InProgress && BitCounter == 7'd40) begin found = 1; break; end
    end
    chk("t5_reach40", found, 1);
    #1 Reset = 1;
    #1;
    chk("t5_InProgress", InProgress, 0);
    chk("t5_BitCounter", BitCounter, 0);
    chk("t5_Busy", Busy, 0);
    chk("t5_WriteOp", WriteOp, 0);
    chk("t5_Mdc", Mdc, 0);
    @(posedge Clk); @(posedge Clk); #2 Reset = 0;
    hits = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      if (InProgress || Busy) hits++;
    end
    chk("t5_no_restart", hits, 0);

    // ---- 6: scan ----
`ifdef ETH_MIIM_SCAN_EN
    @(posedge Clk); #2 ScanStat = 1;
    starts = 0; upd = 0; prevIP = 0;
    per = -1; nEn = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clk);
      if (InProgress && !prevIP) begin
        if (starts == 0) per = Nvalid;
        starts++;
      end
      prevIP = InProgress;
      if (UpdateReadData) begin
        if (upd == 0) nEn = Nvalid;
        upd++;
      end
      if (upd == 3) break;
    end
    chk("t6_nvalid_first", per, 1);
    chk("t6_nvalid_cleared", nEn, 0);
    chk("t6_updates", upd, 3);
    found = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge Clk);
      if (InProgress && BitCounter == 7'd50) begin found = 1; break; end
    end
    chk("t6_reach50", found, 1);
    @(posedge Clk); #2 ScanStat = 0;
    upd = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge Clk);
      if (UpdateReadData) upd++;
      if (!Busy) break;
    end
    chk("t6_last_update", upd, 1);
    hits = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (InProgress || Busy || Nvalid) hits++;
    end
    chk("t6_idle_after", hits, 0);
`else
    @(posedge Clk); #2 ScanStat = 1;
    hits = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (InProgress || Busy || Nvalid) hits++;
    end
    chk("t6_scan_ignored", hits, 0);
    @(posedge Clk); #2 ScanStat = 0;
`endif

    repeat (4) @(negedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
